// File: rtl/cal_pkg.sv
// cal_pkg: shared types and default constants for the calibration scheduler.
package cal_pkg;
  localparam int CAL_N_CH = 8;
  localparam int CAL_W = 16;
  localparam int CAL_COEF_FRAC = 10;
  localparam int UNITY_GAIN = 1 << CAL_COEF_FRAC;
  localparam int CAL_CLAMP_HI = 32000;
  localparam int CAL_CLAMP_LO = -32000;
  typedef logic signed [CAL_W-1:0] sample_t;
  typedef logic signed [CAL_W-1:0] coef_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} cal_state_e;
endpackage

// File: rtl/cal_mac_clamp.sv
// cal_mac_clamp: subtract-offset register stage, then combinational multiply, shift and clamp.
module cal_mac_clamp
  import cal_pkg::*;
#(
  parameter int W = CAL_W,
  parameter int CW = 3,
  parameter int COEF_FRAC = CAL_COEF_FRAC,
  parameter int CLAMP_HI = CAL_CLAMP_HI,
  parameter int CLAMP_LO = CAL_CLAMP_LO
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic [CW-1:0]        ch_i,
  input  logic signed [W-1:0]  sample_i,
  input  logic signed [W-1:0]  offset_i,
  input  logic signed [W-1:0]  gain_i,
  output logic                 valid_o,
  output logic [CW-1:0]        ch_o,
  output logic signed [W-1:0]  res_o
);
  localparam logic signed [2*W:0] HI = (2*W+1)'(CLAMP_HI);
  localparam logic signed [2*W:0] LO = (2*W+1)'(CLAMP_LO);
  logic                valid_q;
  logic [CW-1:0]       ch_q;
  logic signed [W:0]   diff_q;
  logic signed [W-1:0] gain_q;
  logic signed [2*W:0] prod, shifted;
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ch_q <= '0;
      diff_q <= '0;
      gain_q <= '0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        ch_q <= ch_i;
        diff_q <= (W+1)'(sample_i) - (W+1)'(offset_i);
        gain_q <= gain_i;
      end
    end
  end
  assign prod = (2*W+1)'(diff_q) * (2*W+1)'(gain_q);
  assign shifted = prod >>> COEF_FRAC;
  assign res_o = shifted > HI ? W'(CLAMP_HI) : shifted < LO ? W'(CLAMP_LO) : shifted[W-1:0];
  assign valid_o = valid_q;
  assign ch_o = ch_q;
endmodule

// File: rtl/cal_scheduler.sv
// cal_scheduler: once per sample_clk period runs all channels through one shared MAC/clamp pipeline.
// Define CAL_SCHED_OVERRUN_CNT_EN to add an 8-bit saturating overrun_cnt output.
module cal_scheduler
  import cal_pkg::*;
#(
  parameter int N_CH = CAL_N_CH,
  parameter int W = CAL_W,
  parameter int COEF_FRAC = CAL_COEF_FRAC,
  parameter int CLAMP_HI = CAL_CLAMP_HI,
  parameter int CLAMP_LO = CAL_CLAMP_LO
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sample_clk,
  input  logic [N_CH*W-1:0]           raw_in,
  output logic [N_CH*W-1:0]           cal_out,
  output logic                        out_valid,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [$clog2(2*N_CH)-1:0]   cfg_addr,
  input  logic [W-1:0]                cfg_data,
  input  logic                        cfg_commit,
  output logic                        commit_busy,
  output logic                        overrun
`ifdef CAL_SCHED_OVERRUN_CNT_EN
  ,
  output logic [7:0]                  overrun_cnt
`endif
);
  localparam int CW = $clog2(N_CH);
  localparam int AW = $clog2(2*N_CH);
  cal_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sync1_q, sync2_q, prev_q;
  logic smp_edge, start, issue, done, ignored;
  logic commit_busy_q, overrun_q;
  logic [N_CH*W-1:0] smp_q, staging_q, cal_q;
  logic signed [W-1:0] off_q [N_CH];
  logic signed [W-1:0] gain_q [N_CH];
  logic signed [W-1:0] off_sh_q [N_CH];
  logic signed [W-1:0] gain_sh_q [N_CH];
  logic mac_v;
  logic [CW-1:0] mac_ch;
  logic signed [W-1:0] mac_res;
  assign smp_edge = sync2_q & ~prev_q;
  assign ignored = smp_edge && state_q != IDLE;
  assign done = state_q == DONE;
  assign out_valid = done;
  // During the DONE cycle the fresh staging values are shown directly so data and valid coincide.
  assign cal_out = done ? staging_q : cal_q;
  assign cfg_ready = !commit_busy_q;
  assign commit_busy = commit_busy_q;
  assign overrun = overrun_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    start = 1'b0;
    issue = 1'b0;
    case (state_q)
      IDLE: begin
        start = smp_edge;
        cnt_d = '0;
        state_d = smp_edge ? RUN : IDLE;
      end
      RUN: begin
        issue = 1'b1;
        cnt_d = cnt_q == CW'(N_CH-1) ? '0 : cnt_q + 1'b1;
        state_d = cnt_q == CW'(N_CH-1) ? DRAIN : RUN;
      end
      DRAIN: state_d = cnt_q == CW'(1) ? DONE : DRAIN;
      default: begin
        cnt_d = '0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      {sync1_q, sync2_q, prev_q} <= '0;
      commit_busy_q <= 1'b0;
      overrun_q <= 1'b0;
      smp_q <= '0;
      staging_q <= '0;
      cal_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        off_q[i] <= '0;
        gain_q[i] <= W'(1 << COEF_FRAC);
        off_sh_q[i] <= '0;
        gain_sh_q[i] <= W'(1 << COEF_FRAC);
      end
    end else begin
      {prev_q, sync2_q, sync1_q} <= {sync2_q, sync1_q, sample_clk};
      // A commit requested on the frame-start cycle is left pending for the following frame.
      commit_busy_q <= commit_busy_q ? !start : cfg_commit;
      overrun_q <= overrun_q | ignored;
      if (start) smp_q <= raw_in;
      if (start && commit_busy_q) begin
        off_q <= off_sh_q;
        gain_q <= gain_sh_q;
      end
      if (cfg_valid && cfg_ready) begin
        if (cfg_addr[0]) gain_sh_q[cfg_addr[AW-1:1]] <= cfg_data;
        else off_sh_q[cfg_addr[AW-1:1]] <= cfg_data;
      end
      if (mac_v) staging_q[mac_ch*W +: W] <= mac_res;
      if (done) cal_q <= staging_q;
    end
  end
`ifdef CAL_SCHED_OVERRUN_CNT_EN
  logic [7:0] ovr_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) ovr_cnt_q <= '0;
    else if (ignored && ovr_cnt_q != 8'hFF) ovr_cnt_q <= ovr_cnt_q + 8'd1;
  end
  assign overrun_cnt = ovr_cnt_q;
`endif
  cal_mac_clamp #(
    .W(W), .CW(CW), .COEF_FRAC(COEF_FRAC), .CLAMP_HI(CLAMP_HI), .CLAMP_LO(CLAMP_LO)
  ) u_mac (
    .clk(clk),
    .rst(rst),
    .valid_i(issue),
    .ch_i(cnt_q),
    .sample_i(smp_q[cnt_q*W +: W]),
    .offset_i(off_q[cnt_q]),
    .gain_i(gain_q[cnt_q]),
    .valid_o(mac_v),
    .ch_o(mac_ch),
    .res_o(mac_res)
  );
endmodule

// File: tb/tb_cal_scheduler.sv
// tb_cal_scheduler: scenario tasks drive frames; a scoreboard checks every out_valid against a reference model.
module tb_cal_scheduler;
  localparam int LAT = 13;
  logic clk = 0, rst = 1, sample_clk = 0;
  logic [127:0] raw_in = '0;
  logic [127:0] cal_out;
  logic out_valid, cfg_valid = 0, cfg_ready, cfg_commit = 0, commit_busy, overrun;
  logic [3:0] cfg_addr = '0;
  logic [15:0] cfg_data = '0;
`ifdef CAL_SCHED_OVERRUN_CNT_EN
  logic [7:0] overrun_cnt;
`endif
  int checks = 0, errors = 0, nvalid = 0, cyc = 0, t_start = 0, lat = 0, nv0 = 0;
  int raw_arr [8];
  int m_act_off [8], m_act_gain [8], m_sh_off [8], m_sh_gain [8];
  bit m_pending;
  logic [127:0] exp_q [$];
  logic [127:0] mon_exp;

  cal_scheduler dut (
    .clk(clk), .rst(rst), .sample_clk(sample_clk), .raw_in(raw_in), .cal_out(cal_out),
    .out_valid(out_valid), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_commit(cfg_commit), .commit_busy(commit_busy), .overrun(overrun)
`ifdef CAL_SCHED_OVERRUN_CNT_EN
    , .overrun_cnt(overrun_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      nvalid++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out_valid cal_out=%h", cal_out);
      end else begin
        mon_exp = exp_q.pop_front();
        if (cal_out !== mon_exp) begin
          errors++;
          $display("FAIL frame_data got=%h exp=%h", cal_out, mon_exp);
        end
      end
    end
  end

  function automatic logic [15:0] model_cal(int r, int o, int g);
    longint d, s;
    d = longint'(r) - longint'(o);
    s = (d * longint'(g)) >>> 10;
    if (s > 32000) s = 32000;
    if (s < -32000) s = -32000;
    return 16'(s);
  endfunction

  function automatic logic [127:0] model_frame();
    logic [127:0] f;
    for (int i = 0; i < 8; i++) f[i*16 +: 16] = model_cal(raw_arr[i], m_act_off[i], m_act_gain[i]);
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_act_off[i] = 0; m_act_gain[i] = 1024; m_sh_off[i] = 0; m_sh_gain[i] = 1024;
    end
    m_pending = 0;
    exp_q.delete();
  endtask

  task automatic start_edge(input bit push);
    @(negedge clk);
    if (m_pending) begin
      m_act_off = m_sh_off; m_act_gain = m_sh_gain; m_pending = 0;
    end
    for (int i = 0; i < 8; i++) raw_in[i*16 +: 16] = 16'(raw_arr[i]);
    if (push) exp_q.push_back(model_frame());
    sample_clk = 1;
    t_start = cyc;
  endtask

  task automatic wait_valid(output int l);
    while (!out_valid && cyc - t_start < 40) @(negedge clk);
    l = cyc - t_start;
  endtask

  task automatic release_edge();
    @(negedge clk);
    sample_clk = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cfg_write(input int addr, input int data);
    @(negedge clk);
    cfg_valid = 1; cfg_addr = 4'(addr); cfg_data = 16'(data);
    if (cfg_ready) begin
      if (addr % 2 == 1) m_sh_gain[addr/2] = data;
      else m_sh_off[addr/2] = data;
    end
    @(negedge clk);
    cfg_valid = 0;
  endtask

  task automatic cfg_commit_pulse();
    @(negedge clk);
    cfg_commit = 1;
    m_pending = 1;
    @(negedge clk);
    cfg_commit = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    checks += 5;
    if (cal_out !== '0) begin errors++; $display("FAIL reset_cal_out got=%h exp=0", cal_out); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    if (commit_busy !== 1'b0) begin errors++; $display("FAIL reset_commit_busy got=%b exp=0", commit_busy); end
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_cfg_ready got=%b exp=1", cfg_ready); end
  endtask

  task automatic test_unity();
    for (int i = 0; i < 8; i++) raw_arr[i] = i * 100 - 300;
    raw_arr[3] = 1234;
    start_edge(1);
    wait_valid(lat);
    checks += 2;
    // Detect lands two clocks after the driven edge, then N_CH+3 cycles to DONE.
    if (lat != LAT) begin errors++; $display("FAIL unity_latency got=%0d exp=%0d", lat, LAT); end
    if (cal_out[3*16 +: 16] !== 16'(1234)) begin errors++; $display("FAIL unity_ch3 got=%0d exp=1234", $signed(cal_out[3*16 +: 16])); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL unity_single_pulse got=%b exp=0", out_valid); end
    release_edge();
  endtask

  task automatic test_commit();
    cfg_write(0, 100);
    cfg_write(1, 2048);
    cfg_commit_pulse();
    checks += 2;
    if (commit_busy !== 1'b1) begin errors++; $display("FAIL commit_busy_set got=%b exp=1", commit_busy); end
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL commit_cfg_ready got=%b exp=0", cfg_ready); end
    for (int i = 0; i < 8; i++) raw_arr[i] = 50 * i;
    raw_arr[0] = 1100;
    start_edge(1);
    while (cyc - t_start < 4) @(negedge clk);
    checks++;
    if (commit_busy !== 1'b0) begin errors++; $display("FAIL commit_busy_clear got=%b exp=0", commit_busy); end
    wait_valid(lat);
    checks += 2;
    if (lat != LAT) begin errors++; $display("FAIL commit_latency got=%0d exp=%0d", lat, LAT); end
    if (cal_out[15:0] !== 16'(2000)) begin errors++; $display("FAIL commit_ch0 got=%0d exp=2000", $signed(cal_out[15:0])); end
    release_edge();
  endtask

  task automatic test_clamp();
    cfg_write(3, 4096);
    cfg_write(5, 4096);
    cfg_commit_pulse();
    for (int i = 0; i < 8; i++) raw_arr[i] = 7 * i - 20;
    raw_arr[0] = 0; raw_arr[1] = 20000; raw_arr[2] = -20000; raw_arr[3] = -32768;
    start_edge(1);
    wait_valid(lat);
    checks += 4;
    if (cal_out[15:0] !== 16'(-200)) begin errors++; $display("FAIL clamp_ch0 got=%0d exp=-200", $signed(cal_out[15:0])); end
    if (cal_out[31:16] !== 16'(32000)) begin errors++; $display("FAIL clamp_hi got=%0d exp=32000", $signed(cal_out[31:16])); end
    if (cal_out[47:32] !== 16'(-32000)) begin errors++; $display("FAIL clamp_lo got=%0d exp=-32000", $signed(cal_out[47:32])); end
    if (cal_out[63:48] !== 16'(-32000)) begin errors++; $display("FAIL clamp_min_raw got=%0d exp=-32000", $signed(cal_out[63:48])); end
    release_edge();
  endtask

  task automatic test_cfg_during_run();
    for (int i = 0; i < 8; i++) raw_arr[i] = 10 * i;
    raw_arr[4] = 1000;
    start_edge(1);
    while (cyc - t_start < 5) @(negedge clk);
    checks++;
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL run_cfg_ready got=%b exp=1", cfg_ready); end
    cfg_write(9, 512);
    cfg_commit_pulse();
    checks += 2;
    if (commit_busy !== 1'b1) begin errors++; $display("FAIL run_commit_busy got=%b exp=1", commit_busy); end
    if (cfg_ready !== 1'b0) begin errors++; $display("FAIL run_cfg_ready_busy got=%b exp=0", cfg_ready); end
    wait_valid(lat);
    checks += 2;
    if (lat != LAT) begin errors++; $display("FAIL run_latency got=%0d exp=%0d", lat, LAT); end
    if (cal_out[79:64] !== 16'(1000)) begin errors++; $display("FAIL run_old_gain got=%0d exp=1000", $signed(cal_out[79:64])); end
    release_edge();
    start_edge(1);
    wait_valid(lat);
    checks += 2;
    if (cal_out[79:64] !== 16'(500)) begin errors++; $display("FAIL run_new_gain got=%0d exp=500", $signed(cal_out[79:64])); end
    if (commit_busy !== 1'b0) begin errors++; $display("FAIL run_commit_done got=%b exp=0", commit_busy); end
    release_edge();
  endtask

  task automatic test_overrun();
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_pre got=%b exp=0", overrun); end
    for (int i = 0; i < 8; i++) raw_arr[i] = 3 * i + 1;
    nv0 = nvalid;
    start_edge(1);
    while (cyc - t_start < 2) @(negedge clk);
    sample_clk = 0;
    while (cyc - t_start < 4) @(negedge clk);
    sample_clk = 1;
    wait_valid(lat);
    checks++;
    if (lat != LAT) begin errors++; $display("FAIL overrun_latency got=%0d exp=%0d", lat, LAT); end
    release_edge();
    repeat (16) @(negedge clk);
    checks += 2;
    if (nvalid != nv0 + 1) begin errors++; $display("FAIL overrun_pulses got=%0d exp=%0d", nvalid - nv0, 1); end
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag got=%b exp=1", overrun); end
`ifdef CAL_SCHED_OVERRUN_CNT_EN
    checks++;
    if (overrun_cnt !== 8'd1) begin errors++; $display("FAIL overrun_cnt got=%0d exp=1", overrun_cnt); end
`endif
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) raw_arr[i] = 111 * i;
    start_edge(0);
    while (cyc - t_start < 7) @(negedge clk);
    rst = 1;
    sample_clk = 0;
    @(negedge clk);
    rst = 0;
    model_reset();
    nv0 = nvalid;
    repeat (20) @(negedge clk);
    checks += 4;
    if (nvalid != nv0) begin errors++; $display("FAIL rstmid_no_valid got=%0d exp=0", nvalid - nv0); end
    if (cal_out !== '0) begin errors++; $display("FAIL rstmid_cal_out got=%h exp=0", cal_out); end
    if (overrun !== 1'b0) begin errors++; $display("FAIL rstmid_overrun got=%b exp=0", overrun); end
    if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rstmid_cfg_ready got=%b exp=1", cfg_ready); end
    for (int i = 0; i < 8; i++) raw_arr[i] = 1000 - 250 * i;
    start_edge(1);
    wait_valid(lat);
    checks += 2;
    if (lat != LAT) begin errors++; $display("FAIL rstmid_latency got=%0d exp=%0d", lat, LAT); end
    if (cal_out[31:16] !== 16'(750)) begin errors++; $display("FAIL rstmid_unity_ch1 got=%0d exp=750", $signed(cal_out[31:16])); end
    release_edge();
  endtask

  initial begin
    test_reset();
    test_unity();
    test_commit();
    test_clamp();
    test_cfg_during_run();
    test_overrun();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
